// File: rtl/miriscv_irq_pkg.sv
// Shared types and constants for the miriscv interrupt controller.
package miriscv_irq_pkg;

  localparam int MAX_IRQ        = 32;
  localparam int MCAUSE_INT_BIT = 31;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    ACTIVE = 2'd2,
    FINISH = 2'd3
  } irq_state_e;

  // Line-id width; a single-line controller still needs a 1-bit id.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/miriscv_irq_ctrl_if.sv
// Bundle between the peripherals/core and the interrupt controller.
//
// Handshake: INT_o is a level request; once raised it stays high until the
// core drives INT_RST_i=1 while INT_o is high (one cycle is enough). The
// controller then drops INT_o, pulses int_fin_o for exactly one cycle to the
// served line, and only then may raise INT_o again. INT_RST_i while INT_o is
// low has no effect. mcause_o is valid whenever INT_o is high.
interface miriscv_irq_ctrl_if #(
  parameter int NUM_IRQ = 32
);
  import miriscv_irq_pkg::*;

  logic [NUM_IRQ-1:0] int_req_i;
  logic [NUM_IRQ-1:0] edge_mode_i;
  logic [MAX_IRQ-1:0] mie_i;
  logic               INT_RST_i;
  logic               INT_o;
  logic [31:0]        mcause_o;
  logic [NUM_IRQ-1:0] int_fin_o;

  // Requesting side (peripherals + core).
  modport master (
    output int_req_i, edge_mode_i, mie_i, INT_RST_i,
    input  INT_o, mcause_o, int_fin_o
  );

  // Controller side.
  modport slave (
    input  int_req_i, edge_mode_i, mie_i, INT_RST_i,
    output INT_o, mcause_o, int_fin_o
  );

endinterface

// File: rtl/miriscv_irq_arbiter.sv
// Combinational arbiter: picks one eligible line, either lowest index first
// or lowest index at/after rr_ptr_i with wrap-around.
module miriscv_irq_arbiter
  import miriscv_irq_pkg::*;
#(
  parameter  int NUM_IRQ     = 32,
  parameter  int ROUND_ROBIN = 0,
  localparam int ID_W        = id_width(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] eligible_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  logic [NUM_IRQ-1:0] upper;
  int                 start;

  // Split eligible into lines at/after the start point; search those first,
  // then fall back to the whole vector, which gives the wrap-around order.
  always_comb begin
    start   = (ROUND_ROBIN != 0) ? int'(rr_ptr_i) : 0;
    upper   = '0;
    valid_o = 1'b0;
    id_o    = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      upper[i] = eligible_i[i] && (i >= start);
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (!valid_o && upper[i]) begin
        valid_o = 1'b1;
        id_o    = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (!valid_o && eligible_i[i]) begin
        valid_o = 1'b1;
        id_o    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/miriscv_irq_ctrl.sv
// miriscv interrupt controller: per-line edge/level capture, mie masking,
// arbitration and the INT / mcause / INT_RST handshake with the core.
module miriscv_irq_ctrl
  import miriscv_irq_pkg::*;
#(
  parameter  int NUM_IRQ      = 32,
  parameter  int ROUND_ROBIN  = 0,
  parameter  int CAUSE_OFFSET = 16,
  localparam int ID_W         = id_width(NUM_IRQ)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  miriscv_irq_ctrl_if.slave        bus,
  output irq_state_e               state_o
);

  irq_state_e         state_q;
  logic [NUM_IRQ-1:0] req_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] pending_d;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] fin_onehot;
  logic [NUM_IRQ-1:0] fin_q;
  logic [ID_W-1:0]    irq_id_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    rr_next;
  logic [ID_W-1:0]    arb_id;
  logic               arb_valid;
  logic               int_q;
  logic [31:0]        mcause_q;
  logic [31:0]        arb_cause;
  logic               unused_mie;

  // mie bits above NUM_IRQ have no line behind them.
  assign unused_mie = ^bus.mie_i;

  assign rise     = bus.int_req_i & ~req_q;
  assign eligible = pending_q & bus.mie_i[NUM_IRQ-1:0];
  assign rr_next  = (irq_id_q == ID_W'(NUM_IRQ - 1)) ? '0 : irq_id_q + 1'b1;
  assign arb_cause = (32'(CAUSE_OFFSET) + 32'(arb_id)) | (32'd1 << MCAUSE_INT_BIT);

  miriscv_irq_arbiter #(
    .NUM_IRQ     (NUM_IRQ),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arbiter (
    .eligible_i (eligible),
    .rr_ptr_i   (rr_ptr_q),
    .valid_o    (arb_valid),
    .id_o       (arb_id)
  );

  // Next pending vector: edge lines accumulate rising edges, level lines
  // follow the input; the served edge line is cleared in FINISH unless it
  // sees a fresh edge in that same cycle.
  always_comb begin
    pending_d  = pending_q;
    fin_onehot = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      fin_onehot[i] = (ID_W'(i) == irq_id_q);
      if (bus.edge_mode_i[i]) begin
        if (state_q == FINISH && ID_W'(i) == irq_id_q) begin
          pending_d[i] = rise[i];
        end else begin
          pending_d[i] = pending_q[i] | rise[i];
        end
      end else begin
        pending_d[i] = bus.int_req_i[i];
      end
    end
  end

  // Request sampling and pending capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q     <= '0;
      pending_q <= '0;
    end else begin
      req_q     <= bus.int_req_i;
      pending_q <= pending_d;
    end
  end

  // Service FSM with registered INT / mcause / completion outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      irq_id_q <= '0;
      rr_ptr_q <= '0;
      int_q    <= 1'b0;
      mcause_q <= '0;
      fin_q    <= '0;
    end else begin
      fin_q <= '0;
      case (state_q)
        IDLE: begin
          if (|eligible) state_q <= ARB;
        end
        ARB: begin
          if (arb_valid) begin
            state_q  <= ACTIVE;
            irq_id_q <= arb_id;
            int_q    <= 1'b1;
            mcause_q <= arb_cause;
          end else begin
            state_q <= IDLE;
          end
        end
        ACTIVE: begin
          if (bus.INT_RST_i) begin
            state_q <= FINISH;
            int_q   <= 1'b0;
            fin_q   <= fin_onehot;
          end
        end
        FINISH: begin
          rr_ptr_q <= rr_next;
          mcause_q <= '0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.INT_o     = int_q;
  assign bus.mcause_o  = mcause_q;
  assign bus.int_fin_o = fin_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_miriscv_irq_ctrl.sv
// Bench for miriscv_irq_ctrl: instance A is fixed-priority with edge lines,
// instance B is round-robin with level lines.
module tb_miriscv_irq_ctrl;
  import miriscv_irq_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  miriscv_irq_ctrl_if #(.NUM_IRQ(32)) bus_a ();
  miriscv_irq_ctrl_if #(.NUM_IRQ(32)) bus_b ();
  irq_state_e state_a;
  irq_state_e state_b;

  miriscv_irq_ctrl #(.NUM_IRQ(32), .ROUND_ROBIN(0), .CAUSE_OFFSET(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(bus_a.slave), .state_o(state_a)
  );
  miriscv_irq_ctrl #(.NUM_IRQ(32), .ROUND_ROBIN(1), .CAUSE_OFFSET(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b.slave), .state_o(state_b)
  );

  int total = 0;
  int bad   = 0;
  logic [4:0] exp_q_a[$];
  logic [4:0] exp_q_b[$];

  function automatic logic [31:0] cause_of(input int id);
    return 32'h8000_0000 | (32'd16 + 32'(id));
  endfunction

  // ---------------- scoreboards ----------------
  initial begin
    logic prev_int;
    logic [31:0] prev_fin;
    logic [4:0] cur;
    prev_int = 1'b0; prev_fin = '0; cur = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus_a.INT_o === 1'b1 && !prev_int) begin
          total++;
          if (exp_q_a.size() == 0) begin
            bad++; $display("FAIL sb_a_unexpected: mcause=%h required no interrupt", bus_a.mcause_o);
          end else begin
            cur = exp_q_a.pop_front();
            if (bus_a.mcause_o !== cause_of(int'(cur))) begin
              bad++; $display("FAIL sb_a_cause: got %h want %h", bus_a.mcause_o, cause_of(int'(cur)));
            end
          end
        end
        if (bus_a.int_fin_o !== 32'd0) begin
          total++;
          if (bus_a.int_fin_o !== (32'd1 << cur) || prev_fin !== 32'd0) begin
            bad++; $display("FAIL sb_a_fin: got %h (prev %h) want %h single cycle", bus_a.int_fin_o, prev_fin, 32'd1 << cur);
          end
        end
      end
      prev_int = (bus_a.INT_o === 1'b1);
      prev_fin = bus_a.int_fin_o;
    end
  end

  initial begin
    logic prev_int;
    logic [31:0] prev_fin;
    logic [4:0] cur;
    prev_int = 1'b0; prev_fin = '0; cur = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus_b.INT_o === 1'b1 && !prev_int) begin
          total++;
          if (exp_q_b.size() == 0) begin
            bad++; $display("FAIL sb_b_unexpected: mcause=%h required no interrupt", bus_b.mcause_o);
          end else begin
            cur = exp_q_b.pop_front();
            if (bus_b.mcause_o !== cause_of(int'(cur))) begin
              bad++; $display("FAIL sb_b_cause: got %h want %h", bus_b.mcause_o, cause_of(int'(cur)));
            end
          end
        end
        if (bus_b.int_fin_o !== 32'd0) begin
          total++;
          if (bus_b.int_fin_o !== (32'd1 << cur) || prev_fin !== 32'd0) begin
            bad++; $display("FAIL sb_b_fin: got %h (prev %h) want %h single cycle", bus_b.int_fin_o, prev_fin, 32'd1 << cur);
          end
        end
      end
      prev_int = (bus_b.INT_o === 1'b1);
      prev_fin = bus_b.int_fin_o;
    end
  end

  // ---------------- driver tasks ----------------
  // Wait (bounded) for INT_o, record mcause, ack for one cycle, record int_fin_o.
  task automatic wait_ack(input bit sel, input int budget, output bit ok,
                          output logic [31:0] cause, output logic [31:0] fin);
    ok = 1'b0; cause = '0; fin = '0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clk);
      ok = sel ? (bus_b.INT_o === 1'b1) : (bus_a.INT_o === 1'b1);
    end
    if (ok) begin
      cause = sel ? bus_b.mcause_o : bus_a.mcause_o;
      if (sel) bus_b.INT_RST_i = 1'b1; else bus_a.INT_RST_i = 1'b1;
      @(negedge clk);
      fin = sel ? bus_b.int_fin_o : bus_a.int_fin_o;
      bus_a.INT_RST_i = 1'b0;
      bus_b.INT_RST_i = 1'b0;
    end
  endtask

  task automatic pulse_a(input logic [31:0] lines);
    @(negedge clk);
    bus_a.int_req_i = lines;
    @(negedge clk);
    bus_a.int_req_i = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (bus_a.INT_o !== 1'b0 || bus_b.INT_o !== 1'b0) begin
      bad++; $display("FAIL reset_int: got a=%b b=%b want 0", bus_a.INT_o, bus_b.INT_o); end
    total++; if (bus_a.mcause_o !== 32'd0 || bus_b.mcause_o !== 32'd0) begin
      bad++; $display("FAIL reset_mcause: got a=%h b=%h want 0", bus_a.mcause_o, bus_b.mcause_o); end
    total++; if (bus_a.int_fin_o !== 32'd0 || bus_b.int_fin_o !== 32'd0) begin
      bad++; $display("FAIL reset_fin: got a=%h b=%h want 0", bus_a.int_fin_o, bus_b.int_fin_o); end
    total++; if (state_a !== IDLE || state_b !== IDLE) begin
      bad++; $display("FAIL reset_state: got a=%0d b=%0d want IDLE", state_a, state_b); end
    rst = 1'b0;
  endtask

  task automatic test_edge_latency();
    bus_a.mie_i = 32'h8;
    @(negedge clk);
    bus_a.int_req_i[3] = 1'b1;
    exp_q_a.push_back(5'd3);
    @(negedge clk);
    bus_a.int_req_i[3] = 1'b0;
    total++; if (bus_a.INT_o !== 1'b0) begin bad++; $display("FAIL lat_k: INT got %b want 0", bus_a.INT_o); end
    @(negedge clk);
    total++; if (bus_a.INT_o !== 1'b0) begin bad++; $display("FAIL lat_k1: INT got %b want 0", bus_a.INT_o); end
    @(negedge clk);
    total++; if (bus_a.INT_o !== 1'b1) begin bad++; $display("FAIL lat_k2: INT got %b want 1", bus_a.INT_o); end
    total++; if (bus_a.mcause_o !== 32'h8000_0013) begin
      bad++; $display("FAIL lat_cause: got %h want 80000013", bus_a.mcause_o); end
    bus_a.INT_RST_i = 1'b1;
    @(negedge clk);
    bus_a.INT_RST_i = 1'b0;
    total++; if (bus_a.INT_o !== 1'b0) begin bad++; $display("FAIL ack_int: got %b want 0", bus_a.INT_o); end
    total++; if (bus_a.int_fin_o !== 32'h8) begin bad++; $display("FAIL ack_fin: got %h want 8", bus_a.int_fin_o); end
    total++; if (bus_a.mcause_o !== 32'h8000_0013) begin
      bad++; $display("FAIL fin_cause_hold: got %h want 80000013", bus_a.mcause_o); end
    @(negedge clk);
    total++; if (bus_a.int_fin_o !== 32'h0 || bus_a.mcause_o !== 32'h0 || state_a !== IDLE) begin
      bad++; $display("FAIL post_fin: fin=%h mcause=%h state=%0d want 0/0/IDLE", bus_a.int_fin_o, bus_a.mcause_o, state_a); end
  endtask

  task automatic test_fixed_priority();
    logic [4:0] ids [2] = '{5'd2, 5'd5};
    bit ok; logic [31:0] cause; logic [31:0] fin;
    bus_a.mie_i = '1;
    exp_q_a.push_back(5'd2);
    exp_q_a.push_back(5'd5);
    pulse_a((32'd1 << 5) | (32'd1 << 2));
    for (int n = 0; n < 2; n++) begin
      wait_ack(1'b0, 20, ok, cause, fin);
      total++; if (!ok) begin bad++; $display("FAIL fp_timeout%0d: INT got 0 want 1", n); end
      total++; if (cause !== cause_of(int'(ids[n]))) begin
        bad++; $display("FAIL fp_cause%0d: got %h want %h", n, cause, cause_of(int'(ids[n]))); end
      total++; if (fin !== (32'd1 << ids[n])) begin
        bad++; $display("FAIL fp_fin%0d: got %h want %h", n, fin, 32'd1 << ids[n]); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [4:0] ids [4] = '{5'd1, 5'd4, 5'd1, 5'd4};
    bit ok; logic [31:0] cause; logic [31:0] fin; bit quiet;
    for (int n = 0; n < 4; n++) exp_q_b.push_back(ids[n]);
    @(negedge clk);
    bus_b.int_req_i = (32'd1 << 1) | (32'd1 << 4);
    for (int n = 0; n < 4; n++) begin
      wait_ack(1'b1, 20, ok, cause, fin);
      total++; if (!ok) begin bad++; $display("FAIL rr_timeout%0d: INT got 0 want 1", n); end
      total++; if (cause !== cause_of(int'(ids[n]))) begin
        bad++; $display("FAIL rr_cause%0d: got %h want %h", n, cause, cause_of(int'(ids[n]))); end
      total++; if (fin !== (32'd1 << ids[n])) begin
        bad++; $display("FAIL rr_fin%0d: got %h want %h", n, fin, 32'd1 << ids[n]); end
    end
    bus_b.int_req_i = '0;
    quiet = 1'b1;
    repeat (6) begin @(negedge clk); if (bus_b.INT_o !== 1'b0) quiet = 1'b0; end
    total++; if (!quiet) begin bad++; $display("FAIL rr_quiet: INT got 1 want 0 after drop"); end
  endtask

  task automatic test_mask();
    bit ok; logic [31:0] cause; logic [31:0] fin; bit quiet;
    bus_a.mie_i = ~(32'd1 << 7);
    pulse_a(32'd1 << 7);
    quiet = 1'b1;
    repeat (20) begin @(negedge clk); if (bus_a.INT_o !== 1'b0) quiet = 1'b0; end
    total++; if (!quiet) begin bad++; $display("FAIL mask_hold: INT got 1 want 0 while masked"); end
    exp_q_a.push_back(5'd7);
    bus_a.mie_i = '1;
    wait_ack(1'b0, 20, ok, cause, fin);
    total++; if (!ok) begin bad++; $display("FAIL mask_timeout: INT got 0 want 1"); end
    total++; if (cause !== 32'h8000_0017) begin bad++; $display("FAIL mask_cause: got %h want 80000017", cause); end
    total++; if (fin !== 32'h80) begin bad++; $display("FAIL mask_fin: got %h want 80", fin); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ok; logic [31:0] cause; logic [31:0] fin; bit quiet;
    bus_a.mie_i = '1;
    exp_q_a.push_back(5'd3);
    pulse_a(32'd1 << 3);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin @(negedge clk); ok = (bus_a.INT_o === 1'b1); end
    total++; if (!ok) begin bad++; $display("FAIL b2b_first: INT got 0 want 1"); end
    // Edge while the same line is in service.
    bus_a.int_req_i[3] = 1'b1;
    @(negedge clk);
    bus_a.int_req_i[3] = 1'b0;
    @(negedge clk);
    bus_a.INT_RST_i = 1'b1;
    @(negedge clk);
    // Now in FINISH: a fresh edge sampled on the next clock must survive.
    total++; if (bus_a.int_fin_o !== 32'h8) begin bad++; $display("FAIL b2b_fin1: got %h want 8", bus_a.int_fin_o); end
    bus_a.INT_RST_i = 1'b0;
    bus_a.int_req_i[3] = 1'b1;
    exp_q_a.push_back(5'd3);
    @(negedge clk);
    bus_a.int_req_i[3] = 1'b0;
    wait_ack(1'b0, 20, ok, cause, fin);
    total++; if (!ok) begin bad++; $display("FAIL b2b_second: INT got 0 want 1"); end
    total++; if (cause !== 32'h8000_0013) begin bad++; $display("FAIL b2b_cause: got %h want 80000013", cause); end
    total++; if (fin !== 32'h8) begin bad++; $display("FAIL b2b_fin2: got %h want 8", fin); end
    quiet = 1'b1;
    repeat (12) begin @(negedge clk); if (bus_a.INT_o !== 1'b0) quiet = 1'b0; end
    total++; if (!quiet) begin bad++; $display("FAIL b2b_quiet: INT got 1 want 0"); end
  endtask

  task automatic test_reset_mid_service();
    bit ok; bit quiet;
    exp_q_a.push_back(5'd9);
    pulse_a(32'd1 << 9);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin @(negedge clk); ok = (bus_a.INT_o === 1'b1); end
    total++; if (!ok) begin bad++; $display("FAIL rst_mid_active: INT got 0 want 1"); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus_a.INT_o !== 1'b0 || bus_a.mcause_o !== 32'd0 || bus_a.int_fin_o !== 32'd0) begin
      bad++; $display("FAIL rst_mid_out: INT=%b mcause=%h fin=%h want 0/0/0", bus_a.INT_o, bus_a.mcause_o, bus_a.int_fin_o); end
    total++; if (state_a !== IDLE) begin bad++; $display("FAIL rst_mid_state: got %0d want IDLE", state_a); end
    rst = 1'b0;
    quiet = 1'b1;
    repeat (10) begin @(negedge clk); if (bus_a.INT_o !== 1'b0 || bus_a.int_fin_o !== 32'd0) quiet = 1'b0; end
    total++; if (!quiet) begin bad++; $display("FAIL rst_mid_lost: INT/fin got activity want none"); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus_a.int_req_i = '0; bus_a.edge_mode_i = '1; bus_a.mie_i = '1; bus_a.INT_RST_i = 1'b0;
    bus_b.int_req_i = '0; bus_b.edge_mode_i = '0; bus_b.mie_i = '1; bus_b.INT_RST_i = 1'b0;
    test_reset();
    test_edge_latency();
    test_fixed_priority();
    test_round_robin();
    test_mask();
    test_back_to_back();
    test_reset_mid_service();
    total++; if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
      bad++; $display("FAIL sb_leftover: a=%0d b=%0d want 0/0", exp_q_a.size(), exp_q_b.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
